// File: rtl/ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module      : ifu_fetch
// Description : Instruction fetch unit feeding the IF/ID register. Owns the
//               PC, issues word fetches over a req/gnt/rvalid handshake,
//               buffers returned words with their addresses in a small FIFO
//               and supports downstream stall plus a one-cycle jump/flush.
// Revision    : 1.0 - initial release
// ============================================================================
module ifu_fetch #(
    parameter int unsigned       ADDR_W     = 32,
    parameter int unsigned       DATA_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = {ADDR_W{1'b0}},
    parameter logic [DATA_W-1:0] NOP_INST   = 32'h00000013,
    parameter int unsigned       FIFO_DEPTH = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_gnt_i,
    input  logic              imem_rvalid_i,
    input  logic [DATA_W-1:0] imem_rdata_i,
    input  logic              stall_i,
    input  logic              jump_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    output logic              inst_valid_o,
    output logic [ADDR_W-1:0] inst_addr_o,
    output logic [DATA_W-1:0] inst_o
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // Pointer width indexes the FIFO; counters need one more bit so that a
    // completely full FIFO (or FIFO_DEPTH outstanding requests) is encodable.
    localparam int unsigned c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned c_CNT_W = c_PTR_W + 1;
    // Slot-claim sum (count + outstanding) can reach 2*FIFO_DEPTH transiently
    // in arithmetic, so it gets one extra bit of headroom.
    localparam int unsigned c_SUM_W = c_CNT_W + 1;

    localparam logic [c_SUM_W-1:0] c_DEPTH   = c_SUM_W'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0]  c_PC_STEP = ADDR_W'(4);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

    // ------------------------------------------------------------------------
    // State machine encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,   // first cycle after reset release, no fetch
        ST_RUN   = 2'd1,   // normal fetching
        ST_FLUSH = 2'd2    // waiting for stale responses of a redirect
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [ADDR_W-1:0]  r_pc;           // next address to request
    logic [ADDR_W-1:0]  r_resp_pc;      // address of the next kept response
    logic [c_CNT_W-1:0] r_outstanding;  // granted but not yet returned
    logic [c_CNT_W-1:0] r_drop_cnt;     // responses still to be discarded
    logic [c_CNT_W-1:0] r_count;        // FIFO occupancy
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0]  r_addr_mem [FIFO_DEPTH];
    logic [DATA_W-1:0]  r_data_mem [FIFO_DEPTH];

    // ------------------------------------------------------------------------
    // Combinational wires
    // ------------------------------------------------------------------------
    logic               w_req;
    logic               w_gnt;
    logic               w_rsp;
    logic               w_push;
    logic               w_pop;
    logic               w_head_valid;
    logic [c_CNT_W-1:0] w_out_keep;
    logic [c_CNT_W-1:0] w_drop_dec;
    logic [c_SUM_W-1:0] w_claims;
    logic [ADDR_W-1:0]  w_jump_pc;
    logic               w_unused_jump_lsb;

    // Redirect target is always word aligned; the low bits are don't-care.
    assign w_jump_pc         = {jump_addr_i[ADDR_W-1:2], 2'b00};
    assign w_unused_jump_lsb = ^jump_addr_i[1:0];

    assign w_head_valid = (r_count != '0);

    // A jump overrides the pop so the FIFO is simply cleared instead.
    assign w_pop = w_head_valid & ~stall_i & ~jump_i;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign w_rsp = imem_rvalid_i & (r_outstanding != '0);

    // Responses are kept only outside a drop window and never in a jump cycle.
    assign w_push = w_rsp & (r_drop_cnt == '0) & ~jump_i;

    // Outstanding requests left after this cycle's response, not counting a
    // new grant. In a jump cycle there is never a grant, so this is also the
    // number of responses that must be discarded after the redirect.
    assign w_out_keep = r_outstanding - c_CNT_W'(w_rsp);

    assign w_drop_dec = (w_rsp && (r_drop_cnt != '0)) ? (r_drop_cnt - c_CNT_ONE)
                                                      : r_drop_cnt;

    // Slots already claimed by buffered plus in-flight words. A pop this
    // cycle frees its slot before any response to a request issued now can
    // land (earliest one cycle after grant), so it is credited immediately;
    // this is what sustains one instruction per cycle with a 1-cycle memory.
    assign w_claims = {1'b0, r_count} + {1'b0, r_outstanding}
                    - {{c_CNT_W{1'b0}}, w_pop};

    assign w_gnt = w_req & imem_gnt_i;

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and fetch request decode
    always_comb begin
        w_state_next = r_state;
        w_req        = 1'b0;
        case (r_state)
            ST_BOOT: begin
                w_state_next = ST_RUN;
            end
            ST_RUN: begin
                w_req = ~jump_i & (w_claims < c_DEPTH);
                if (jump_i && (w_out_keep != '0)) begin
                    w_state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                // A redirect with nothing left in flight can fetch the new
                // target right away; otherwise wait for the last stale word.
                if (jump_i) begin
                    w_state_next = (w_out_keep != '0) ? ST_FLUSH : ST_RUN;
                end else if (w_drop_dec == '0) begin
                    w_state_next = ST_RUN;
                end
            end
            default: begin
                w_state_next = ST_BOOT;
            end
        endcase
    end

    // Request PC and response-address tracking
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_pc      <= RESET_PC;
            r_resp_pc <= RESET_PC;
        end else if (jump_i) begin
            r_pc      <= w_jump_pc;
            r_resp_pc <= w_jump_pc;
        end else begin
            if (w_gnt) begin
                r_pc <= r_pc + c_PC_STEP;
            end
            if (w_push) begin
                r_resp_pc <= r_resp_pc + c_PC_STEP;
            end
        end
    end

    // In-flight and drop accounting
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else begin
            r_outstanding <= w_out_keep + c_CNT_W'(w_gnt);
            r_drop_cnt    <= jump_i ? w_out_keep : w_drop_dec;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (jump_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
        end
    end

    // FIFO storage; contents are only observed while occupancy marks them valid
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_addr_mem[r_wr_ptr] <= r_resp_pc;
            r_data_mem[r_wr_ptr] <= imem_rdata_i;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign imem_req_o   = w_req;
    assign imem_addr_o  = r_pc;
    assign inst_valid_o = w_head_valid;
    assign inst_addr_o  = w_head_valid ? r_addr_mem[r_rd_ptr] : {ADDR_W{1'b0}};
    assign inst_o       = w_head_valid ? r_data_mem[r_rd_ptr] : NOP_INST;

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifu_fetch
// Description : Directed bench for ifu_fetch with a behavioural instruction
//               memory (configurable grant and response delay). Memory words
//               are the address XOR a fixed tag so address and data paths
//               are distinguishable.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifu_fetch;

    localparam logic [31:0] c_NOP   = 32'h0000_0013;
    localparam logic [31:0] c_MAGIC = 32'h5A00_0000;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        stall_i;
    logic        jump_i;
    logic [31:0] jump_addr_i;
    logic        inst_valid_o;
    logic [31:0] inst_addr_o;
    logic [31:0] inst_o;

    always #5 clk_i = ~clk_i;

    ifu_fetch #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .RESET_PC  (32'h0),
        .NOP_INST  (32'h0000_0013),
        .FIFO_DEPTH(2)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_gnt_i   (imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i (imem_rdata_i),
        .stall_i      (stall_i),
        .jump_i       (jump_i),
        .jump_addr_i  (jump_addr_i),
        .inst_valid_o (inst_valid_o),
        .inst_addr_o  (inst_addr_o),
        .inst_o       (inst_o)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Memory model configuration (written only by the main sequence)
    bit          gnt_rand     = 1'b0;
    bit          gnt_on       = 1'b1;
    bit          clear_on_rst = 1'b1;
    int unsigned delay_min    = 1;
    int unsigned delay_max    = 1;

    // Memory model state (written only by the model)
    int          cyc = 0;
    logic [31:0] pend_addr [$];
    int          pend_due  [$];

    // In-order memory: grant decided each cycle, response returned once its
    // due cycle is reached; only one response per cycle.
    initial begin : mem_model
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        forever begin
            @(posedge clk_i);
            cyc = cyc + 1;
            #2;
            if (!rst_i && clear_on_rst) begin
                pend_addr.delete();
                pend_due.delete();
            end
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = '0;
            if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
                imem_rvalid_i = 1'b1;
                imem_rdata_i  = pend_addr[0] ^ c_MAGIC;
                void'(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end
            imem_gnt_i = gnt_rand ? ($urandom_range(0, 1) == 1) : gnt_on;
            @(negedge clk_i);
            if (rst_i && imem_req_o && imem_gnt_i) begin
                pend_addr.push_back(imem_addr_o);
                pend_due.push_back(cyc + int'($urandom_range(delay_min, delay_max)));
            end
        end
    end

    // Reset with a clean memory; returns 1 ns into cycle 0 (BOOT cycle)
    task automatic do_reset(input int unsigned dmin, input int unsigned dmax);
        clear_on_rst = 1'b1;
        gnt_rand     = 1'b0;
        gnt_on       = 1'b1;
        delay_min    = dmin;
        delay_max    = dmax;
        stall_i      = 1'b0;
        jump_i       = 1'b0;
        jump_addr_i  = '0;
        rst_i        = 1'b0;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b1;
    endtask

    // Advance to 1 ns after the next rising edge
    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        stall_i = 1'b0; jump_i = 1'b0; jump_addr_i = '0;
        delay_min = 1; delay_max = 1; gnt_on = 1'b1; clear_on_rst = 1'b1;
        rst_i = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        n_checks++;
        if (imem_req_o !== 1'b0) $display("FAIL reset_req: got %b expected 0", imem_req_o);
        else n_pass++;
        n_checks++;
        if (imem_addr_o !== 32'h0) $display("FAIL reset_imem_addr: got %h expected 00000000", imem_addr_o);
        else n_pass++;
        n_checks++;
        if (inst_valid_o !== 1'b0) $display("FAIL reset_valid: got %b expected 0", inst_valid_o);
        else n_pass++;
        n_checks++;
        if (inst_addr_o !== 32'h0) $display("FAIL reset_inst_addr: got %h expected 00000000", inst_addr_o);
        else n_pass++;
        n_checks++;
        if (inst_o !== c_NOP) $display("FAIL reset_inst: got %h expected %h", inst_o, c_NOP);
        else n_pass++;
        @(posedge clk_i);
        #1 rst_i = 1'b1;
        @(negedge clk_i);
        n_checks++;
        if ({imem_req_o, inst_valid_o} !== 2'b00)
            $display("FAIL boot_no_req: got req=%b valid=%b expected 0 0", imem_req_o, inst_valid_o);
        else n_pass++;
    endtask

    task automatic test_stream();
        logic [31:0] e;
        do_reset(1, 1);
        for (int c = 0; c <= 12; c++) begin
            if (c > 0) next_cycle();
            @(negedge clk_i);
            if (c == 1 || c == 2) begin
                e = 32'(c - 1) << 2;
                n_checks++;
                if ({imem_req_o, imem_addr_o} !== {1'b1, e})
                    $display("FAIL stream_req c%0d: got req=%b addr=%h expected 1 %h", c, imem_req_o, imem_addr_o, e);
                else n_pass++;
            end
            if (c < 3) begin
                n_checks++;
                if ({inst_valid_o, inst_o} !== {1'b0, c_NOP})
                    $display("FAIL stream_empty c%0d: got valid=%b inst=%h expected 0 %h", c, inst_valid_o, inst_o, c_NOP);
                else n_pass++;
            end else begin
                e = 32'(c - 3) << 2;
                n_checks++;
                if ({inst_valid_o, inst_addr_o, inst_o} !== {1'b1, e, e ^ c_MAGIC})
                    $display("FAIL stream_out c%0d: got v=%b a=%h d=%h expected 1 %h %h", c, inst_valid_o, inst_addr_o, inst_o, e, e ^ c_MAGIC);
                else n_pass++;
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] e;
        e = 32'h0;
        do_reset(1, 1);
        for (int c = 1; c <= 20; c++) begin
            next_cycle();
            stall_i = (c >= 7 && c <= 11);
            @(negedge clk_i);
            if (c >= 3) begin
                n_checks++;
                if ({inst_valid_o, inst_addr_o, inst_o} !== {1'b1, e, e ^ c_MAGIC})
                    $display("FAIL stall_out c%0d: got v=%b a=%h d=%h expected 1 %h %h", c, inst_valid_o, inst_addr_o, inst_o, e, e ^ c_MAGIC);
                else n_pass++;
                if (!stall_i) e = e + 32'd4;
            end
            if (stall_i) begin
                n_checks++;
                if (imem_req_o !== 1'b0) $display("FAIL stall_req_drop c%0d: got %b expected 0", c, imem_req_o);
                else n_pass++;
            end
            if (c == 12) begin
                n_checks++;
                if ({imem_req_o, imem_addr_o} !== {1'b1, 32'h18})
                    $display("FAIL stall_resume_req: got req=%b addr=%h expected 1 00000018", imem_req_o, imem_addr_o);
                else n_pass++;
            end
        end
        stall_i = 1'b0;
    endtask

    task automatic test_jump_outstanding();
        do_reset(3, 3);
        for (int c = 1; c <= 11; c++) begin
            next_cycle();
            jump_i      = (c == 3);
            jump_addr_i = 32'h103;
            @(negedge clk_i);
            if (c == 1 || c == 2) begin
                n_checks++;
                if ({imem_req_o, imem_addr_o} !== {1'b1, 32'(c - 1) << 2})
                    $display("FAIL jo_req c%0d: got req=%b addr=%h", c, imem_req_o, imem_addr_o);
                else n_pass++;
            end
            if (c >= 3 && c <= 5) begin
                n_checks++;
                if (imem_req_o !== 1'b0) $display("FAIL jo_no_req c%0d: got %b expected 0", c, imem_req_o);
                else n_pass++;
            end
            if (c == 6) begin
                n_checks++;
                if ({imem_req_o, imem_addr_o} !== {1'b1, 32'h100})
                    $display("FAIL jo_target_req: got req=%b addr=%h expected 1 00000100", imem_req_o, imem_addr_o);
                else n_pass++;
            end
            if (c >= 3 && c <= 9) begin
                n_checks++;
                if (inst_valid_o !== 1'b0) $display("FAIL jo_dropped c%0d: got valid=%b addr=%h expected 0", c, inst_valid_o, inst_addr_o);
                else n_pass++;
            end
            if (c == 10 || c == 11) begin
                n_checks++;
                if ({inst_valid_o, inst_addr_o, inst_o} !== {1'b1, 32'h100 + (32'(c - 10) << 2), (32'h100 + (32'(c - 10) << 2)) ^ c_MAGIC})
                    $display("FAIL jo_out c%0d: got v=%b a=%h d=%h", c, inst_valid_o, inst_addr_o, inst_o);
                else n_pass++;
            end
        end
        jump_i = 1'b0;
    endtask

    task automatic test_jump_rvalid_wrap();
        do_reset(1, 1);
        for (int c = 1; c <= 11; c++) begin
            next_cycle();
            jump_i      = (c == 6);
            jump_addr_i = 32'hFFFF_FFFE;
            @(negedge clk_i);
            if (c == 6) begin
                n_checks++;
                if ({inst_valid_o, inst_addr_o, imem_req_o} !== {1'b1, 32'h0C, 1'b0})
                    $display("FAIL jw_jump_cycle: got v=%b a=%h req=%b expected 1 0000000c 0", inst_valid_o, inst_addr_o, imem_req_o);
                else n_pass++;
            end
            if (c == 7 || c == 8) begin
                n_checks++;
                if ({inst_valid_o, inst_o, imem_req_o, imem_addr_o} !== {1'b0, c_NOP, 1'b1, 32'hFFFF_FFFC + (32'(c - 7) << 2)})
                    $display("FAIL jw_req c%0d: got v=%b d=%h req=%b addr=%h", c, inst_valid_o, inst_o, imem_req_o, imem_addr_o);
                else n_pass++;
            end
            if (c >= 9) begin
                n_checks++;
                if ({inst_valid_o, inst_addr_o, inst_o} !== {1'b1, 32'hFFFF_FFFC + (32'(c - 9) << 2), (32'hFFFF_FFFC + (32'(c - 9) << 2)) ^ c_MAGIC})
                    $display("FAIL jw_out c%0d: got v=%b a=%h d=%h", c, inst_valid_o, inst_addr_o, inst_o);
                else n_pass++;
            end
        end
        jump_i = 1'b0;
    endtask

    task automatic test_jump_full_stall();
        do_reset(1, 1);
        for (int c = 1; c <= 11; c++) begin
            next_cycle();
            stall_i     = (c >= 5 && c <= 7);
            jump_i      = (c == 7);
            jump_addr_i = 32'h201;
            @(negedge clk_i);
            if (c == 6 || c == 7) begin
                n_checks++;
                if ({inst_valid_o, inst_addr_o, imem_req_o} !== {1'b1, 32'h8, 1'b0})
                    $display("FAIL jf_full c%0d: got v=%b a=%h req=%b expected 1 00000008 0", c, inst_valid_o, inst_addr_o, imem_req_o);
                else n_pass++;
            end
            if (c == 8) begin
                n_checks++;
                if ({inst_valid_o, inst_addr_o, inst_o, imem_req_o, imem_addr_o} !== {1'b0, 32'h0, c_NOP, 1'b1, 32'h200})
                    $display("FAIL jf_flushed: got v=%b a=%h d=%h req=%b addr=%h expected 0 0 %h 1 00000200", inst_valid_o, inst_addr_o, inst_o, imem_req_o, imem_addr_o, c_NOP);
                else n_pass++;
            end
            if (c == 10 || c == 11) begin
                n_checks++;
                if ({inst_valid_o, inst_addr_o, inst_o} !== {1'b1, 32'h200 + (32'(c - 10) << 2), (32'h200 + (32'(c - 10) << 2)) ^ c_MAGIC})
                    $display("FAIL jf_out c%0d: got v=%b a=%h d=%h", c, inst_valid_o, inst_addr_o, inst_o);
                else n_pass++;
            end
        end
        stall_i = 1'b0;
        jump_i  = 1'b0;
    endtask

    task automatic test_random_mem();
        logic [31:0] e;
        int          n_out;
        e     = 32'h0;
        n_out = 0;
        do_reset(1, 4);
        gnt_rand = 1'b1;
        for (int c = 1; c <= 400; c++) begin
            next_cycle();
            stall_i = ($urandom_range(0, 3) == 0);
            @(negedge clk_i);
            if (inst_valid_o) begin
                n_checks++;
                if ({inst_addr_o, inst_o} !== {e, e ^ c_MAGIC})
                    $display("FAIL rand_order c%0d: got a=%h d=%h expected %h %h", c, inst_addr_o, inst_o, e, e ^ c_MAGIC);
                else n_pass++;
                if (!stall_i) begin
                    e     = e + 32'd4;
                    n_out = n_out + 1;
                end
            end
        end
        n_checks++;
        if (n_out < 40) $display("FAIL rand_progress: got %0d instructions expected at least 40", n_out);
        else n_pass++;
        stall_i  = 1'b0;
        gnt_rand = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset(4, 4);
        clear_on_rst = 1'b0;
        for (int c = 1; c <= 13; c++) begin
            next_cycle();
            if (c == 3) begin
                rst_i  = 1'b0;
                gnt_on = 1'b0;
            end
            if (c == 4) rst_i = 1'b1;
            if (c == 7) gnt_on = 1'b1;
            @(negedge clk_i);
            if (c == 3 || c == 4) begin
                n_checks++;
                if ({imem_req_o, imem_addr_o, inst_valid_o} !== {1'b0, 32'h0, 1'b0})
                    $display("FAIL rm_cleared c%0d: got req=%b addr=%h v=%b expected 0 0 0", c, imem_req_o, imem_addr_o, inst_valid_o);
                else n_pass++;
            end
            if (c >= 5 && c <= 7) begin
                n_checks++;
                if ({imem_req_o, imem_addr_o} !== {1'b1, 32'h0})
                    $display("FAIL rm_restart_req c%0d: got req=%b addr=%h expected 1 00000000", c, imem_req_o, imem_addr_o);
                else n_pass++;
            end
            if (c >= 5 && c <= 11) begin
                n_checks++;
                if (inst_valid_o !== 1'b0)
                    $display("FAIL rm_stale_ignored c%0d: got valid=%b addr=%h expected 0", c, inst_valid_o, inst_addr_o);
                else n_pass++;
            end
            if (c == 12 || c == 13) begin
                n_checks++;
                if ({inst_valid_o, inst_addr_o, inst_o} !== {1'b1, 32'(c - 12) << 2, (32'(c - 12) << 2) ^ c_MAGIC})
                    $display("FAIL rm_out c%0d: got v=%b a=%h d=%h", c, inst_valid_o, inst_addr_o, inst_o);
                else n_pass++;
            end
        end
        clear_on_rst = 1'b1;
    endtask

    initial begin : main
        rst_i       = 1'b0;
        stall_i     = 1'b0;
        jump_i      = 1'b0;
        jump_addr_i = '0;
        test_reset();
        test_stream();
        test_stall();
        test_jump_outstanding();
        test_jump_rvalid_wrap();
        test_jump_full_stall();
        test_random_mem();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected completion (%0d/%0d so far)", n_pass, n_checks);
        $fatal(1, "simulation timeout");
    end

endmodule
`default_nettype wire
